// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard tracker: finds the youngest in-flight writer of each source, selects its stage for forwarding, and stalls on loads that are not ready yet.
// Optional build macro HAZARD_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module hazard_forward_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic                         issue_wen,
    input  logic [ADDR_W-1:0]            issue_wreg,
    input  logic                         issue_is_load,
    input  logic [ADDR_W-1:0]            src1,
    input  logic [ADDR_W-1:0]            src2,
    input  logic                         src1_used,
    input  logic                         src2_used,
    input  logic                         flush,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel2
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

    // Index 0 holds stage 1 (youngest writer).
    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_wreg [DEPTH];
    logic [CNT_W-1:0]  ent_cnt  [DEPTH];

    logic [DEPTH-1:0]  hit1;
    logic [DEPTH-1:0]  hit2;
    logic [DEPTH-1:0]  pend;
    logic [SEL_W-1:0]  sel1;
    logic [SEL_W-1:0]  sel2;
    logic              busy1;
    logic              busy2;
    logic              push;
    logic [CNT_W-1:0]  push_cnt;

    // Per-entry source match and not-yet-ready flags.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        pend = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            hit1[k] = ent_valid[k] && (ent_wreg[k] != '0) && (ent_wreg[k] == src1) && src1_used;
            hit2[k] = ent_valid[k] && (ent_wreg[k] != '0) && (ent_wreg[k] == src2) && src2_used;
            pend[k] = (ent_cnt[k] != '0);
        end
    end

    // Scan oldest to youngest so the youngest hit overrides any older one.
    always_comb begin
        sel1  = '0;
        sel2  = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (hit1[k]) begin
                sel1  = SEL_W'(k + 1);
                busy1 = pend[k];
            end
            if (hit2[k]) begin
                sel2  = SEL_W'(k + 1);
                busy2 = pend[k];
            end
        end
    end

    assign stall    = issue_valid & (busy1 | busy2);
    assign fwd_sel1 = sel1;
    assign fwd_sel2 = sel2;

    assign push     = issue_valid & issue_wen & ~stall;
    assign push_cnt = (push && issue_is_load) ? CNT_W'(LOAD_LAT) : '0;

    // Writer pipeline: shift each cycle, count down load latency, clear on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                ent_wreg[k] <= '0;
                ent_cnt[k]  <= '0;
            end
        end else if (flush) begin
            ent_valid <= '0;
        end else begin
            ent_valid[0] <= push;
            ent_wreg[0]  <= issue_wreg;
            ent_cnt[0]   <= push_cnt;
            for (int k = 1; k < int'(DEPTH); k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wreg[k]  <= ent_wreg[k-1];
                ent_cnt[k]   <= (ent_cnt[k-1] != '0) ? ent_cnt[k-1] - CNT_W'(1) : '0;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating count of bubbles actually inserted (flush cycles excluded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed hazard scenarios plus random traffic against an age-based reference model.
module tb_hazard_forward_unit;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DEPTH    = 3;
    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned SEL_W    = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_wen;
    logic [ADDR_W-1:0] issue_wreg;
    logic              issue_is_load;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic              src1_used;
    logic              src2_used;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_sel1;
    logic [SEL_W-1:0]  fwd_sel2;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    hazard_forward_unit #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_wen    (issue_wen),
        .issue_wreg   (issue_wreg),
        .issue_is_load(issue_is_load),
        .src1         (src1),
        .src2         (src2),
        .src1_used    (src1_used),
        .src2_used    (src2_used),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stage s holds the writer accepted s cycles ago.
    bit                mv [DEPTH+1];
    logic [ADDR_W-1:0] mr [DEPTH+1];
    bit                ml [DEPTH+1];
    int                e_sel1;
    int                e_sel2;
    bit                e_stall;
    int unsigned       m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A load accepted s cycles ago is forwardable once s exceeds LOAD_LAT.
    task automatic find(input logic [ADDR_W-1:0] src, input logic used, output int sel, output bit busy);
        sel  = 0;
        busy = 1'b0;
        for (int s = 1; s <= int'(DEPTH); s++) begin
            if (sel == 0 && used && src != '0 && mv[s] && mr[s] == src) begin
                sel  = s;
                busy = ml[s] && (s <= int'(LOAD_LAT));
            end
        end
    endtask

    task automatic model_eval();
        bit b1;
        bit b2;
        find(src1, src1_used, e_sel1, b1);
        find(src2, src2_used, e_sel2, b2);
        e_stall = issue_valid && (b1 || b2);
    endtask

    task automatic model_step();
        if (flush) begin
            for (int s = 1; s <= int'(DEPTH); s++) mv[s] = 1'b0;
        end else begin
            for (int s = int'(DEPTH); s >= 2; s--) begin
                mv[s] = mv[s-1];
                mr[s] = mr[s-1];
                ml[s] = ml[s-1];
            end
            mv[1] = issue_valid && issue_wen && !e_stall;
            mr[1] = issue_wreg;
            ml[1] = issue_is_load;
        end
        if (e_stall && !flush && m_cnt < 32'hFFFF) m_cnt++;
    endtask

    task automatic model_reset();
        for (int s = 0; s <= int'(DEPTH); s++) mv[s] = 1'b0;
        m_cnt = 0;
    endtask

    task automatic zero_inputs();
        issue_valid   = 1'b0;
        issue_wen     = 1'b0;
        issue_wreg    = '0;
        issue_is_load = 1'b0;
        src1          = '0;
        src2          = '0;
        src1_used     = 1'b0;
        src2_used     = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check({tag, ".sel1"}, 32'(fwd_sel1), 32'(e_sel1));
        check({tag, ".sel2"}, 32'(fwd_sel2), 32'(e_sel2));
`ifdef HAZARD_STALL_CNT_EN
        check({tag, ".cnt"}, 32'(stall_cnt), m_cnt);
`endif
    endtask

    // Drive one decode cycle at the falling edge and compare against the model.
    task automatic drive(input string tag, input logic v, input logic wen, input logic [ADDR_W-1:0] wreg,
                         input logic ld, input logic [ADDR_W-1:0] s1, input logic u1,
                         input logic [ADDR_W-1:0] s2, input logic u2, input logic fl);
        @(negedge clk);
        issue_valid   = v;
        issue_wen     = wen;
        issue_wreg    = wreg;
        issue_is_load = ld;
        src1          = s1;
        src1_used     = u1;
        src2          = s2;
        src2_used     = u2;
        flush         = fl;
        #1;
        model_eval();
        check_outputs(tag);
    endtask

    task automatic advance();
        model_eval();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        #1;
        model_eval();
        check_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        model_eval();
        check_outputs("por");
        check("por.stall_const", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance();

        // Non-load producer forwards from stage 1, then stage 2.
        drive("alu_w", 1, 1, 5, 0, 0, 0, 0, 0, 0); advance();
        drive("alu_u1", 1, 0, 0, 0, 5, 1, 0, 0, 0);
        check("alu_u1.sel1_const", 32'(fwd_sel1), 32'd1);
        check("alu_u1.stall_const", 32'(stall), 32'd0);
        advance();
        drive("alu_u2", 1, 0, 0, 0, 5, 1, 0, 0, 0);
        check("alu_u2.sel1_const", 32'(fwd_sel1), 32'd2);
        advance();

        // Load-use: one bubble, then forward from stage 2.
        drive("ld_fl", 0, 0, 0, 0, 0, 0, 0, 0, 1); advance();
        drive("ld_w", 1, 1, 7, 1, 0, 0, 0, 0, 0); advance();
        drive("ld_u1", 1, 0, 0, 0, 0, 0, 7, 1, 0);
        check("ld_u1.stall_const", 32'(stall), 32'd1);
        advance();
        drive("ld_u2", 1, 0, 0, 0, 0, 0, 7, 1, 0);
        check("ld_u2.stall_const", 32'(stall), 32'd0);
        check("ld_u2.sel2_const", 32'(fwd_sel2), 32'd2);
        advance();

        // Two writers to r3: youngest wins; r0 and unused sources never forward.
        drive("r3_fl", 0, 0, 0, 0, 0, 0, 0, 0, 1); advance();
        drive("r3_w1", 1, 1, 3, 0, 0, 0, 0, 0, 0); advance();
        drive("r3_w2", 1, 1, 3, 0, 0, 0, 0, 0, 0); advance();
        drive("r3_u", 1, 0, 0, 0, 3, 1, 3, 1, 0);
        check("r3_u.sel1_const", 32'(fwd_sel1), 32'd1);
        check("r3_u.sel2_const", 32'(fwd_sel2), 32'd1);
        src1 = '0;
        src2_used = 1'b0;
        #1;
        check("r3_src0.sel1", 32'(fwd_sel1), 32'd0);
        check("r3_unused.sel2", 32'(fwd_sel2), 32'd0);
        advance();

        // Flush wipes the pending load and discards the simultaneous issue.
        drive("fl_ld", 1, 1, 9, 1, 0, 0, 0, 0, 0); advance();
        drive("fl_iss", 1, 1, 4, 0, 0, 0, 0, 0, 1); advance();
        drive("fl_u9", 1, 0, 0, 0, 9, 1, 0, 0, 0);
        check("fl_u9.stall_const", 32'(stall), 32'd0);
        check("fl_u9.sel1_const", 32'(fwd_sel1), 32'd0);
        advance();
        drive("fl_u4", 1, 0, 0, 0, 4, 1, 0, 0, 0);
        check("fl_u4.sel1_const", 32'(fwd_sel1), 32'd0);
        advance();

        // Asynchronous reset while stalled drops stall without a clock edge.
        drive("ar_w", 1, 1, 7, 1, 0, 0, 0, 0, 0); advance();
        drive("ar_u", 1, 0, 0, 0, 7, 1, 0, 0, 0);
        check("ar_u.stall_const", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.stall", 32'(stall), 32'd0);
        check("ar.sel1", 32'(fwd_sel1), 32'd0);
        check("ar.sel2", 32'(fwd_sel2), 32'd0);
        do_reset();

`ifdef HAZARD_STALL_CNT_EN
        // Three load-use bubbles, then saturation at the top of the range.
        for (int i = 0; i < 3; i++) begin
            drive("cnt_w", 1, 1, ADDR_W'(10 + i), 1, 0, 0, 0, 0, 0); advance();
            drive("cnt_u", 1, 0, 0, 0, ADDR_W'(10 + i), 1, 0, 0, 0); advance();
        end
        drive("cnt_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("cnt3", 32'(stall_cnt), 32'd3);
        advance();
        @(negedge clk);
        force dut.stall_cnt = 16'hFFFF;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFF;
        drive("sat_w", 1, 1, 12, 1, 0, 0, 0, 0, 0); advance();
        drive("sat_u", 1, 0, 0, 0, 12, 1, 0, 0, 0); advance();
        drive("sat_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("cnt_sat", 32'(stall_cnt), 32'hFFFF);
        advance();
        do_reset();
`endif

        // Random traffic over a small register window to provoke frequent hits.
        for (int i = 0; i < 600; i++) begin
            drive("rnd",
                  $urandom_range(0, 4) != 0,
                  1'($urandom_range(0, 1)),
                  ADDR_W'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  ADDR_W'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  ADDR_W'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
